// File: rtl/ktop_ctrl_pkg.sv
// rtl/ktop_ctrl_pkg.sv - shared types and constants for the ktop control sequencer
package ktop_ctrl_pkg;

  localparam int LP_MAX_CHANNELS    = 32;
  localparam int LP_RUN_COUNT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } ktop_ctrl_state_t;

endpackage

// File: rtl/ktop_sat_counter.sv
// rtl/ktop_sat_counter.sv - saturating up-counter with synchronous clear and enable
module ktop_sat_counter #(
  parameter int C_WIDTH = 32
) (
  input  logic               ap_clk,
  input  logic               areset,
  input  logic               clr,
  input  logic               en,
  output logic [C_WIDTH-1:0] cnt,
  output logic [C_WIDTH-1:0] cnt_inc
);

  // cnt_inc is the saturated successor, exported so callers can act on it this cycle
  assign cnt_inc = (&cnt) ? cnt : cnt + C_WIDTH'(1);

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/ktop_ctrl_seq.sv
// rtl/ktop_ctrl_seq.sv - kernel start/done sequencer with channel mask, timeout, auto-restart and run stats
module ktop_ctrl_seq
  import ktop_ctrl_pkg::*;
#(
  parameter int C_NUM_CHANNELS    = 2,
  parameter int C_CYCLE_CNT_WIDTH = 32,
  parameter int C_TIMEOUT_WIDTH   = 32
) (
  input  logic                          ap_clk,
  input  logic                          areset,
  input  logic                          ap_start,
  input  logic                          ctrl_auto_restart,
  input  logic [C_NUM_CHANNELS-1:0]     ctrl_chan_en,
  input  logic [C_TIMEOUT_WIDTH-1:0]    ctrl_timeout,
  input  logic [C_NUM_CHANNELS-1:0]     chan_done,
  output logic [C_NUM_CHANNELS-1:0]     chan_start,
  output logic                          ap_idle,
  output logic                          ap_done,
  output logic                          ap_ready,
  output logic [C_CYCLE_CNT_WIDTH-1:0]  stat_cycles,
  output logic                          stat_timeout,
  output logic [C_NUM_CHANNELS-1:0]     stat_timeout_mask,
  output logic [LP_RUN_COUNT_WIDTH-1:0] stat_run_count
);

  localparam int LP_CMP_W = (C_CYCLE_CNT_WIDTH > C_TIMEOUT_WIDTH) ? C_CYCLE_CNT_WIDTH : C_TIMEOUT_WIDTH;

  ktop_ctrl_state_t state, state_next;

  logic                         ap_start_r;
  logic                         start_evt;
  logic                         latch_cfg;
  logic [C_NUM_CHANNELS-1:0]    mask_r;
  logic [C_TIMEOUT_WIDTH-1:0]   tmo_r;
  logic [C_NUM_CHANNELS-1:0]    pending_r;
  logic [C_NUM_CHANNELS-1:0]    pending_live;
  logic                         all_done;
  logic                         tmo_hit;
  logic                         cnt_clr;
  logic                         cnt_en;
  logic [C_CYCLE_CNT_WIDTH-1:0] cnt;
  logic [C_CYCLE_CNT_WIDTH-1:0] cnt_inc;
  logic [LP_CMP_W-1:0]          cnt_cmp;
  logic [LP_CMP_W-1:0]          tmo_cmp;

  assign start_evt    = ap_start & ~ap_start_r;
  assign pending_live = pending_r & ~chan_done;
  assign all_done     = ~|pending_live;
  assign cnt_cmp      = LP_CMP_W'(cnt_inc);
  assign tmo_cmp      = LP_CMP_W'(tmo_r);
  assign tmo_hit      = (tmo_r != '0) && (cnt_cmp == tmo_cmp);

  // Config is sampled both on a fresh start from IDLE and on an auto-restart out of DONE
  assign latch_cfg = ((state == ST_IDLE) && start_evt) ||
                     ((state == ST_DONE) && ctrl_auto_restart && ap_start);

  // Counter reads 0 in every LAUNCH cycle, so it holds cycles elapsed since chan_start
  assign cnt_clr = (state == ST_IDLE) || (state == ST_DONE);
  assign cnt_en  = (state == ST_LAUNCH) || (state == ST_RUN);

  ktop_sat_counter #(
    .C_WIDTH (C_CYCLE_CNT_WIDTH)
  ) u_run_cnt (
    .ap_clk  (ap_clk),
    .areset  (areset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .cnt     (cnt),
    .cnt_inc (cnt_inc)
  );

  assign chan_start = (state == ST_LAUNCH) ? mask_r : '0;
  assign ap_idle    = (state == ST_IDLE);
  assign ap_done    = (state == ST_DONE);
  assign ap_ready   = (state == ST_DONE);

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_evt) begin
          state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_next = (mask_r == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        // Completion is tested first so it wins over a coincident timeout
        if (all_done || tmo_hit) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = (ctrl_auto_restart && ap_start) ? ST_LAUNCH : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      ap_start_r        <= 1'b0;
      mask_r            <= '0;
      tmo_r             <= '0;
      pending_r         <= '0;
      stat_cycles       <= '0;
      stat_timeout      <= 1'b0;
      stat_timeout_mask <= '0;
      stat_run_count    <= '0;
    end else begin
      ap_start_r <= ap_start;

      if (latch_cfg) begin
        mask_r <= ctrl_chan_en;
        tmo_r  <= ctrl_timeout;
      end

      case (state)
        ST_LAUNCH: begin
          pending_r <= mask_r;
          if (mask_r == '0) begin
            stat_cycles       <= '0;
            stat_timeout      <= 1'b0;
            stat_timeout_mask <= '0;
            stat_run_count    <= stat_run_count + LP_RUN_COUNT_WIDTH'(1);
          end
        end
        ST_RUN: begin
          pending_r <= pending_live;
          if (all_done) begin
            stat_cycles       <= cnt_inc;
            stat_timeout      <= 1'b0;
            stat_timeout_mask <= '0;
            stat_run_count    <= stat_run_count + LP_RUN_COUNT_WIDTH'(1);
          end else if (tmo_hit) begin
            // cnt_inc equals the latched timeout here
            stat_cycles       <= cnt_inc;
            stat_timeout      <= 1'b1;
            stat_timeout_mask <= pending_live;
            stat_run_count    <= stat_run_count + LP_RUN_COUNT_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ktop_ctrl_seq.sv
// tb/tb_ktop_ctrl_seq.sv - directed vector bench for ktop_ctrl_seq
module tb_ktop_ctrl_seq;

  logic        ap_clk;
  logic        areset;
  logic        ap_start;
  logic        ctrl_auto_restart;
  logic [1:0]  ctrl_chan_en;
  logic [31:0] ctrl_timeout;
  logic [1:0]  chan_done;
  logic [1:0]  chan_start;
  logic        ap_idle;
  logic        ap_done;
  logic        ap_ready;
  logic [31:0] stat_cycles;
  logic        stat_timeout;
  logic [1:0]  stat_timeout_mask;
  logic [31:0] stat_run_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        st;
    logic [1:0]  en;
    logic [31:0] tmo;
    logic [1:0]  d;
    logic [1:0]  cs;
    logic        idle;
    logic        dn;
    logic        sc;
    logic [31:0] cyc;
    logic        to;
    logic [1:0]  tm;
    logic [31:0] runs;
  } vec_t;

  vec_t vecs[$];

  ktop_ctrl_seq #(
    .C_NUM_CHANNELS    (2),
    .C_CYCLE_CNT_WIDTH (32),
    .C_TIMEOUT_WIDTH   (32)
  ) dut (
    .ap_clk            (ap_clk),
    .areset            (areset),
    .ap_start          (ap_start),
    .ctrl_auto_restart (ctrl_auto_restart),
    .ctrl_chan_en      (ctrl_chan_en),
    .ctrl_timeout      (ctrl_timeout),
    .chan_done         (chan_done),
    .chan_start        (chan_start),
    .ap_idle           (ap_idle),
    .ap_done           (ap_done),
    .ap_ready          (ap_ready),
    .stat_cycles       (stat_cycles),
    .stat_timeout      (stat_timeout),
    .stat_timeout_mask (stat_timeout_mask),
    .stat_run_count    (stat_run_count)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_stats(input string tag, input logic [31:0] cyc, input logic to,
                           input logic [1:0] tm, input logic [31:0] runs);
    chk({tag, " stat_cycles"}, stat_cycles, cyc);
    chk({tag, " stat_timeout"}, 32'(stat_timeout), 32'(to));
    chk({tag, " stat_timeout_mask"}, 32'(stat_timeout_mask), 32'(tm));
    chk({tag, " stat_run_count"}, stat_run_count, runs);
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] cs, input logic idle, input logic dn);
    chk({tag, " chan_start"}, 32'(chan_start), 32'(cs));
    chk({tag, " ap_idle"}, 32'(ap_idle), 32'(idle));
    chk({tag, " ap_done"}, 32'(ap_done), 32'(dn));
    chk({tag, " ap_ready"}, 32'(ap_ready), 32'(dn));
  endtask

  task automatic r(input logic st, input logic [1:0] en, input logic [31:0] tmo, input logic [1:0] d,
                   input logic [1:0] cs, input logic idle, input logic dn);
    vec_t v;
    v.st = st; v.en = en; v.tmo = tmo; v.d = d;
    v.cs = cs; v.idle = idle; v.dn = dn;
    v.sc = 1'b0; v.cyc = '0; v.to = 1'b0; v.tm = '0; v.runs = '0;
    vecs.push_back(v);
  endtask

  task automatic s(input logic [31:0] cyc, input logic to, input logic [1:0] tm, input logic [31:0] runs);
    vec_t v;
    v = vecs[vecs.size()-1];
    v.sc = 1'b1; v.cyc = cyc; v.to = to; v.tm = tm; v.runs = runs;
    vecs[vecs.size()-1] = v;
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  int ndone;

  initial begin
    areset = 1'b1;
    ap_start = 1'b0;
    ctrl_auto_restart = 1'b0;
    ctrl_chan_en = 2'b00;
    ctrl_timeout = '0;
    chan_done = 2'b00;

    // basic: both channels, done[0] at +5, done[1] at +10
    r(1, 3, 0, 0, 0, 1, 0);
    r(1, 0, 0, 0, 3, 0, 0);
    for (int k = 0; k < 3; k++) r(1, 0, 0, 0, 0, 0, 0);
    r(1, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) r(1, 0, 0, 0, 0, 0, 0);
    r(1, 0, 0, 2, 0, 0, 0);
    r(1, 0, 0, 0, 0, 0, 1); s(10, 0, 2'b00, 1);
    r(0, 0, 0, 0, 0, 1, 0);
    // timeout 8, done[1] during LAUNCH ignored, only done[0] returns
    r(1, 3, 8, 0, 0, 1, 0);
    r(1, 0, 0, 2, 3, 0, 0);
    r(1, 0, 0, 0, 0, 0, 0);
    r(1, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) r(1, 0, 0, 0, 0, 0, 0);
    r(1, 0, 0, 0, 0, 0, 1); s(8, 1, 2'b10, 2);
    r(0, 0, 0, 0, 0, 1, 0);
    // channel 0 only, stray done[1]
    r(1, 1, 0, 0, 0, 1, 0);
    r(1, 0, 0, 0, 1, 0, 0);
    r(1, 0, 0, 2, 0, 0, 0);
    r(1, 0, 0, 0, 0, 0, 0);
    r(1, 0, 0, 1, 0, 0, 0);
    r(1, 0, 0, 0, 0, 0, 1); s(4, 0, 2'b00, 3);
    r(0, 0, 0, 0, 0, 1, 0);
    // zero mask
    r(1, 0, 0, 0, 0, 1, 0);
    r(1, 0, 0, 0, 0, 0, 0);
    r(1, 0, 0, 0, 0, 0, 1); s(0, 0, 2'b00, 4);
    r(0, 0, 0, 0, 0, 1, 0);
    // final done coincides with timeout 5; start edge during RUN and repeated done ignored
    r(1, 3, 5, 0, 0, 1, 0);
    r(1, 0, 0, 0, 3, 0, 0);
    r(0, 0, 0, 0, 0, 0, 0);
    r(1, 0, 0, 1, 0, 0, 0);
    r(1, 0, 0, 1, 0, 0, 0);
    r(1, 0, 0, 2, 0, 0, 0);
    r(1, 0, 0, 0, 0, 0, 1); s(5, 0, 2'b00, 5);
    r(1, 0, 0, 3, 0, 1, 0);
    r(1, 0, 0, 0, 0, 1, 0);
    r(0, 0, 0, 0, 0, 1, 0);

    repeat (3) @(posedge ap_clk);
    #1;
    areset = 1'b0;
    #3;
    chk_outs("reset", 2'b00, 1'b1, 1'b0);
    chk_stats("reset", 0, 1'b0, 2'b00, 0);
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      ap_start     = vecs[i].st;
      ctrl_chan_en = vecs[i].en;
      ctrl_timeout = vecs[i].tmo;
      chan_done    = vecs[i].d;
      #3;
      chk_outs($sformatf("v%0d", i), vecs[i].cs, vecs[i].idle, vecs[i].dn);
      if (vecs[i].sc) chk_stats($sformatf("v%0d", i), vecs[i].cyc, vecs[i].to, vecs[i].tm, vecs[i].runs);
      step();
    end

    // auto-restart: three back-to-back runs, ap_start dropped in the third DONE
    ctrl_auto_restart = 1'b1;
    ctrl_chan_en = 2'b01;
    ctrl_timeout = '0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      ap_start  = (c < 9);
      chan_done = ((c % 3 == 2) && (c < 9)) ? 2'b01 : 2'b00;
      #3;
      chk_outs($sformatf("ar%0d", c),
               ((c % 3 == 1) && (c < 9)) ? 2'b01 : 2'b00,
               (c == 0) || (c >= 10),
               (c > 0) && (c % 3 == 0) && (c <= 9));
      if (ap_done) ndone++;
      step();
    end
    chk("ar done_count", 32'(ndone), 32'd3);
    chk_stats("ar", 2, 1'b0, 2'b00, 8);
    ctrl_auto_restart = 1'b0;

    // reset mid-run with ap_start held high, then a clean run
    ctrl_chan_en = 2'b11;
    chan_done = 2'b00;
    ap_start = 1'b1;
    #3; chk_outs("rm0", 2'b00, 1'b1, 1'b0); step();
    #3; chk_outs("rm1", 2'b11, 1'b0, 1'b0); step();
    #3; chk_outs("rm2", 2'b00, 1'b0, 1'b0); step();
    areset = 1'b1;
    step();
    areset = 1'b0;
    #3;
    chk_outs("rm_reset", 2'b00, 1'b1, 1'b0);
    chk_stats("rm_reset", 0, 1'b0, 2'b00, 0);
    step();
    #3; chk_outs("rm5", 2'b11, 1'b0, 1'b0); step();
    chan_done = 2'b11;
    #3; chk_outs("rm6", 2'b00, 1'b0, 1'b0); step();
    chan_done = 2'b00;
    ap_start = 1'b0;
    #3;
    chk_outs("rm7", 2'b00, 1'b0, 1'b1);
    chk_stats("rm7", 2, 1'b0, 2'b00, 1);
    step();
    #3; chk_outs("rm8", 2'b00, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ktop_ctrl_seq.md
# ktop_ctrl_seq

Parametrised kernel control sequencer for the ktop kernel wrapper. It converts the SDx `ap_start` level into one-cycle start pulses for up to `C_NUM_CHANNELS` datapath engines and tracks per-channel completion. It generates `ap_idle`, `ap_done` and `ap_ready`. Beyond a basic start/done wrapper, it adds a per-run channel-enable mask, an optional timeout, auto-restart, and run statistics (cycle count, timeout mask, run count).

## Interface
- `C_NUM_CHANNELS`, default 2: number of engine channels, legal range 1..32.
- `C_CYCLE_CNT_WIDTH`, default 32: width of the run cycle counter and of `stat_cycles`.
- `C_TIMEOUT_WIDTH`, default 32: width of `ctrl_timeout`.

Ports (one clock; reset is synchronous and active-high):
- `ap_clk`  in  1  sole clock.
- `areset`  in  1  synchronous, active-high reset.
- `ap_start`  in  1  level start request from the control register.
- `ctrl_auto_restart`  in  1  when 1, a new run launches directly from DONE while `ap_start` is still high.
- `ctrl_chan_en`  in  `C_NUM_CHANNELS`  channel-enable mask, sampled at launch.
- `ctrl_timeout`  in  `C_TIMEOUT_WIDTH`  run timeout in cycles, sampled at launch; 0 disables the timeout.
- `chan_done`  in  `C_NUM_CHANNELS`  one-cycle completion pulse from each engine.
- `chan_start`  out  `C_NUM_CHANNELS`  one-cycle start pulse, driven only on enabled channels.
- `ap_idle`  out  1  high while no run is active.
- `ap_done`  out  1  one-cycle pulse at run completion.
- `ap_ready`  out  1  one-cycle pulse, coincident with `ap_done`.
- `stat_cycles`  out  `C_CYCLE_CNT_WIDTH`  cycle count of the last completed run.
- `stat_timeout`  out  1  high if the last run ended by timeout.
- `stat_timeout_mask`  out  `C_NUM_CHANNELS`  channels still pending when the last run timed out.
- `stat_run_count`  out  32  number of completed runs, wrapping.

## Operation
- `ap_start_r` registers `ap_start` every cycle. A start event is `ap_start & ~ap_start_r`.
- The state machine has four states: IDLE, LAUNCH, RUN, DONE.
- **IDLE**
  - `ap_idle`=1; run counter held at 0.
  - On a start event, latch `mask`=`ctrl_chan_en` and `tmo`=`ctrl_timeout`, then go to LAUNCH.
- **LAUNCH** (one cycle)
  - `chan_start`=`mask`; `pending`<=`mask`; counter<=1.
  - `chan_done` is ignored in this cycle.
  - If `mask`==0, go to DONE with `stat_cycles`<=0; otherwise go to RUN.
- **RUN**
  - Each cycle: `pending` <= `pending & ~chan_done`. Done pulses on non-pending or disabled channels are ignored.
  - The counter increments each cycle and saturates at all-ones.
  - Completion: when `(pending & ~chan_done)`==0, go to DONE.
    - `stat_cycles` <= counter+1 (saturating), i.e. cycles from the `chan_start` cycle to the final `chan_done` cycle, inclusive.
    - `stat_timeout`<=0; `stat_timeout_mask`<=0.
  - Timeout: when `tmo`!=0, counter+1==`tmo`, and pending survives this cycle, go to DONE.
    - `stat_timeout`<=1; `stat_timeout_mask`<=remaining pending; `stat_cycles`<=`tmo`.
  - If a done completing all pending arrives in the same cycle as the timeout, completion wins.
- **DONE** (one cycle)
  - `ap_done`=`ap_ready`=1; `stat_run_count`++.
  - If `ctrl_auto_restart` && `ap_start`: go to LAUNCH, re-sampling mask and timeout; `ap_idle` stays 0.
  - Otherwise go to IDLE.
  - A further run from IDLE needs a new rising edge of `ap_start`.
- A start event while not in IDLE is ignored.
- **Reset** at any point, including mid-run:
  - Next state is IDLE; `ap_start_r`=0.
  - `chan_start`=0, `ap_done`=0, `ap_ready`=0, `ap_idle`=1.
  - All `stat_*` outputs=0.
  - If `ap_start` is held high across reset, the first post-reset cycle produces a start event.

## Timing
- All outputs are registered or decoded from the state register. There is no combinational path from inputs to outputs.
- Start event seen in cycle t: `chan_start` and `ap_idle`=0 appear in cycle t+1.
- Final `chan_done` in cycle d: `ap_done` in cycle d+1; `ap_idle`=1 in cycle d+2 (non-restart case).
- Auto-restart: the DONE cycle is followed immediately by the LAUNCH cycle. Back-to-back run overhead is 2 cycles.
- Stats update on the same edge that enters DONE, so they are valid while `ap_done`=1 and hold until the next DONE or reset.

## Structure
- Package `ktop_ctrl_pkg` holds:
  - the state typedef `ktop_ctrl_state_t` (IDLE, LAUNCH, RUN, DONE);
  - localparam `LP_MAX_CHANNELS`=32;
  - localparam `LP_RUN_COUNT_WIDTH`=32.
- One sub-module, `ktop_sat_counter`: a parametrised-width saturating counter with synchronous clear and enable, used for the run cycle counter.

## Test plan
- **Basic run:** `ctrl_chan_en`=2'b11, timeout 0; start at cycle 10; `chan_done[0]` at 15, `chan_done[1]` at 20 → `chan_start`=2'b11 at cycle 11, `ap_done` at cycle 21, `stat_cycles`=10, `stat_run_count`=1, `ap_idle` high at cycle 22.
- **Timeout:** `ctrl_timeout`=8, only `chan_done[0]` returns → `ap_done` 8 cycles after LAUNCH, `stat_timeout`=1, `stat_timeout_mask`=2'b10, `stat_cycles`=8.
- **Masked and zero mask:** `ctrl_chan_en`=2'b01 → `chan_start`=2'b01; a stray `chan_done[1]` is ignored. Mask 0 → `ap_done` 2 cycles after the start event, `stat_cycles`=0.
- **Auto-restart:** `ctrl_auto_restart`=1, `ap_start` held high for 3 runs → `ap_idle` stays 0 throughout, `ap_done` pulses 3 times, then drop `ap_start` → return to IDLE.
- **Reset mid-run:** assert `areset` during RUN → next cycle is IDLE with all outputs at reset values; a fresh start event then runs normally.
- **Simultaneous events:** final `chan_done` in the same cycle the timeout would fire → `stat_timeout`=0, and a done on an already-cleared channel does not retrigger anything.
